vect_auto_incr: RTL and testbench

Vector auto-increment address generator for the CGRA control path. Sits between instruction decode and the PC control logic. For each vector instruction it:
- accepts base/stride/length;
- issues one element address per cycle, with stall-based backpressure;
- asserts `done_auto_incr` in the cycle the final element issues, so the PC releases exactly then.

Non-vector instructions pass through untouched.

---
 rtl/cgra_pkg.sv | 14 +
 rtl/vect_auto_incr.sv | 131 +++++++++++++
 tb/tb_vect_auto_incr.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cgra_pkg.sv
// Shared types and default widths for the CGRA control path.
// Provides the auto-increment FSM state type and width defaults.
package cgra_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } vai_state_t;

    localparam int CGRA_ADDR_W   = 12;
    localparam int CGRA_LEN_W    = 12;
    localparam int CGRA_STRIDE_W = 8;

endpackage

// File: rtl/vect_auto_incr.sv
// Vector auto-increment address generator: one element address per
// cycle for base/stride/length vector ops, with stall backpressure.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   is_not_vect     decode: 0 = vector op present
//   vect_base       first element address
//   vect_stride     signed element increment
//   vect_len        element count (0 completes immediately)
//   stall           downstream backpressure, freezes issue
//   addr_out        current element address (registered)
//   addr_valid      addr_out issued this cycle
//   elem_idx        zero-based element index (registered)
//   last_elem       current element is the final one (registered)
//   busy            FSM in RUN (registered)
//   done_auto_incr  vector complete, PC may advance this cycle
module vect_auto_incr
    import cgra_pkg::*;
#(
    parameter int ADDR_W   = CGRA_ADDR_W,
    parameter int LEN_W    = CGRA_LEN_W,
    parameter int STRIDE_W = CGRA_STRIDE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                is_not_vect,
    input  logic [ADDR_W-1:0]   vect_base,
    input  logic [STRIDE_W-1:0] vect_stride,
    input  logic [LEN_W-1:0]    vect_len,
    input  logic                stall,
    output logic [ADDR_W-1:0]   addr_out,
    output logic                addr_valid,
    output logic [LEN_W-1:0]    elem_idx,
    output logic                last_elem,
    output logic                busy,
    output logic                done_auto_incr
);

    vai_state_t        r_state;
    vai_state_t        w_state_nxt;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_stride;
    logic [LEN_W-1:0]  r_idx;
    logic [LEN_W-1:0]  r_rem;
    logic              r_last;

    logic              w_vect;
    logic              w_zero_len;
    logic              w_accept;
    logic              w_adv;
    logic              w_fin;

    assign w_vect     = !is_not_vect;
    assign w_zero_len = (vect_len == '0);
    assign w_accept   = (r_state == IDLE) && w_vect && !w_zero_len;
    assign w_adv      = (r_state == RUN) && !stall;
    assign w_fin      = w_adv && r_last;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_state_nxt = RUN;
            RUN:  if (w_fin)    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic. The zero-length completion path is IDLE-only so
    // decode changes during RUN never reach the PC release.
    always_comb begin
        addr_valid     = 1'b0;
        done_auto_incr = 1'b0;
        if (!rst) begin
            unique case (r_state)
                IDLE: done_auto_incr = w_vect && w_zero_len;
                RUN: begin
                    addr_valid     = !stall;
                    done_auto_incr = w_fin;
                end
                default: begin
                    addr_valid     = 1'b0;
                    done_auto_incr = 1'b0;
                end
            endcase
        end
    end

    // Element datapath. r_rem counts elements not yet issued including
    // the current one, so last_elem is set when it is about to reach 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_stride <= '0;
            r_idx    <= '0;
            r_rem    <= '0;
            r_last   <= 1'b0;
        end else if (w_accept) begin
            r_addr   <= vect_base;
            r_stride <= ADDR_W'($signed(vect_stride));
            r_idx    <= '0;
            r_rem    <= vect_len;
            r_last   <= (vect_len == LEN_W'(1));
        end else if (w_adv) begin
            if (r_last) begin
                r_last <= 1'b0;
            end else begin
                r_addr <= r_addr + r_stride;
                r_idx  <= r_idx + LEN_W'(1);
                r_rem  <= r_rem - LEN_W'(1);
                r_last <= (r_rem == LEN_W'(2));
            end
        end
    end

    assign addr_out  = r_addr;
    assign elem_idx  = r_idx;
    assign last_elem = r_last;
    assign busy      = (r_state == RUN);

endmodule

// File: tb/tb_vect_auto_incr.sv
// Directed self-checking bench for vect_auto_incr.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_vect_auto_incr;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_not_vect;
    logic [11:0] vect_base;
    logic [7:0]  vect_stride;
    logic [11:0] vect_len;
    logic        stall;
    logic [11:0] addr_out;
    logic        addr_valid;
    logic [11:0] elem_idx;
    logic        last_elem;
    logic        busy;
    logic        done_auto_incr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vect_auto_incr dut (
        .clk            (clk),
        .rst            (rst),
        .is_not_vect    (is_not_vect),
        .vect_base      (vect_base),
        .vect_stride    (vect_stride),
        .vect_len       (vect_len),
        .stall          (stall),
        .addr_out       (addr_out),
        .addr_valid     (addr_valid),
        .elem_idx       (elem_idx),
        .last_elem      (last_elem),
        .busy           (busy),
        .done_auto_incr (done_auto_incr)
    );

    task automatic cyc(input logic r, input logic nv,
                       input logic [11:0] b, input logic [7:0] s,
                       input logic [11:0] l, input logic st);
        @(negedge clk);
        rst         = r;
        is_not_vect = nv;
        vect_base   = b;
        vect_stride = s;
        vect_len    = l;
        stall       = st;
        #1;
    endtask

    task automatic idle(input logic st);
        cyc(1'b0, 1'b1, 12'h0, 8'h0, 12'h0, st);
    endtask

    task automatic test_reset;
        cyc(1'b1, 1'b1, 12'h0, 8'h0, 12'h0, 1'b0);
        cyc(1'b1, 1'b1, 12'h0, 8'h0, 12'h0, 1'b0);
        idle(1'b0);
        total++;
        if ({addr_out, addr_valid, elem_idx, last_elem, busy,
             done_auto_incr} !== 28'h0) begin
            bad++;
            $display("FAIL reset addr=%h valid=%b idx=%0d last=%b busy=%b done=%b want all 0",
                     addr_out, addr_valid, elem_idx, last_elem, busy, done_auto_incr);
        end
    endtask

    task automatic test_basic;
        logic [11:0] ea;
        cyc(1'b0, 1'b0, 12'h010, 8'd2, 12'd4, 1'b0);
        total++;
        if (busy !== 1'b0 || done_auto_incr !== 1'b0 || addr_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_accept busy=%b done=%b valid=%b want 0/0/0",
                     busy, done_auto_incr, addr_valid);
        end
        for (int k = 0; k < 4; k++) begin
            idle(1'b0);
            ea = 12'h010 + 12'(2 * k);
            total++;
            if (addr_out !== ea || addr_valid !== 1'b1 ||
                elem_idx !== 12'(k) || busy !== 1'b1 ||
                last_elem !== (k == 3) || done_auto_incr !== (k == 3)) begin
                bad++;
                $display("FAIL basic_elem%0d addr=%h valid=%b idx=%0d last=%b done=%b busy=%b want addr=%h valid=1 idx=%0d last=%b done=%b busy=1",
                         k, addr_out, addr_valid, elem_idx, last_elem,
                         done_auto_incr, busy, ea, k, k == 3, k == 3);
            end
        end
        idle(1'b0);
        total++;
        if (busy !== 1'b0 || done_auto_incr !== 1'b0 || addr_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_end busy=%b done=%b valid=%b want 0/0/0",
                     busy, done_auto_incr, addr_valid);
        end
    endtask

    task automatic test_zero_len;
        cyc(1'b0, 1'b0, 12'h123, 8'd5, 12'd0, 1'b1);
        total++;
        if (done_auto_incr !== 1'b1 || addr_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_len_a done=%b valid=%b busy=%b want 1/0/0",
                     done_auto_incr, addr_valid, busy);
        end
        idle(1'b0);
        total++;
        if (done_auto_incr !== 1'b0 || addr_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_len_next done=%b valid=%b busy=%b want 0/0/0",
                     done_auto_incr, addr_valid, busy);
        end
    endtask

    task automatic test_wrap;
        logic [11:0] exp_a [3];
        exp_a = '{12'h001, 12'h000, 12'hFFF};
        cyc(1'b0, 1'b0, 12'h001, 8'hFF, 12'd3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            total++;
            if (addr_out !== exp_a[k] || addr_valid !== 1'b1 ||
                elem_idx !== 12'(k) || done_auto_incr !== (k == 2)) begin
                bad++;
                $display("FAIL wrap_elem%0d addr=%h valid=%b idx=%0d done=%b want addr=%h valid=1 idx=%0d done=%b",
                         k, addr_out, addr_valid, elem_idx, done_auto_incr,
                         exp_a[k], k, k == 2);
            end
        end
        idle(1'b0);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL wrap_end busy=%b want 0", busy);
        end
    endtask

    task automatic test_stall;
        int pulses = 0;
        cyc(1'b0, 1'b0, 12'h100, 8'd4, 12'd2, 1'b1);
        pulses += int'(done_auto_incr);
        idle(1'b0);
        pulses += int'(done_auto_incr);
        total++;
        if (addr_out !== 12'h100 || addr_valid !== 1'b1 || last_elem !== 1'b0) begin
            bad++;
            $display("FAIL stall_elem0 addr=%h valid=%b last=%b want 100/1/0",
                     addr_out, addr_valid, last_elem);
        end
        for (int k = 0; k < 3; k++) begin
            idle(1'b1);
            pulses += int'(done_auto_incr);
            total++;
            if (addr_out !== 12'h104 || addr_valid !== 1'b0 ||
                done_auto_incr !== 1'b0 || last_elem !== 1'b1 ||
                elem_idx !== 12'd1 || busy !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold%0d addr=%h valid=%b done=%b last=%b idx=%0d busy=%b want 104/0/0/1/1/1",
                         k, addr_out, addr_valid, done_auto_incr, last_elem,
                         elem_idx, busy);
            end
        end
        idle(1'b0);
        pulses += int'(done_auto_incr);
        total++;
        if (addr_out !== 12'h104 || addr_valid !== 1'b1 || done_auto_incr !== 1'b1) begin
            bad++;
            $display("FAIL stall_release addr=%h valid=%b done=%b want 104/1/1",
                     addr_out, addr_valid, done_auto_incr);
        end
        idle(1'b0);
        pulses += int'(done_auto_incr);
        total++;
        if (busy !== 1'b0 || pulses != 1) begin
            bad++;
            $display("FAIL stall_end busy=%b pulses=%0d want 0/1", busy, pulses);
        end
    endtask

    task automatic test_rst_mid;
        int pulses = 0;
        cyc(1'b0, 1'b0, 12'h050, 8'd1, 12'd5, 1'b0);
        idle(1'b0);
        idle(1'b0);
        total++;
        if (elem_idx !== 12'd1 || addr_out !== 12'h051) begin
            bad++;
            $display("FAIL rst_pre idx=%0d addr=%h want 1/051", elem_idx, addr_out);
        end
        cyc(1'b1, 1'b1, 12'h0, 8'h0, 12'h0, 1'b0);
        idle(1'b0);
        pulses += int'(done_auto_incr);
        total++;
        if ({addr_out, addr_valid, elem_idx, last_elem, busy,
             done_auto_incr} !== 28'h0) begin
            bad++;
            $display("FAIL rst_mid addr=%h valid=%b idx=%0d last=%b busy=%b done=%b want all 0",
                     addr_out, addr_valid, elem_idx, last_elem, busy, done_auto_incr);
        end
        for (int k = 0; k < 5; k++) begin
            idle(1'b0);
            pulses += int'(done_auto_incr) + int'(busy);
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL rst_quiet activity=%0d want 0", pulses);
        end
        cyc(1'b0, 1'b0, 12'h0AB, 8'd3, 12'd1, 1'b0);
        idle(1'b0);
        total++;
        if (addr_out !== 12'h0AB || addr_valid !== 1'b1 || last_elem !== 1'b1 ||
            done_auto_incr !== 1'b1 || elem_idx !== 12'd0) begin
            bad++;
            $display("FAIL rst_fresh addr=%h valid=%b last=%b done=%b idx=%0d want 0AB/1/1/1/0",
                     addr_out, addr_valid, last_elem, done_auto_incr, elem_idx);
        end
        idle(1'b0);
        total++;
        if (busy !== 1'b0 || done_auto_incr !== 1'b0) begin
            bad++;
            $display("FAIL rst_fresh_end busy=%b done=%b want 0/0", busy, done_auto_incr);
        end
    endtask

    task automatic test_back_to_back;
        int pulses = 0;
        logic [11:0] exp_a [3];
        exp_a = '{12'h300, 12'h310, 12'h320};
        cyc(1'b0, 1'b0, 12'h200, 8'd1, 12'd2, 1'b0);
        pulses += int'(done_auto_incr);
        idle(1'b0);
        pulses += int'(done_auto_incr);
        cyc(1'b0, 1'b0, 12'h300, 8'h10, 12'd3, 1'b0);
        pulses += int'(done_auto_incr);
        total++;
        if (addr_out !== 12'h201 || done_auto_incr !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first_done addr=%h done=%b want 201/1",
                     addr_out, done_auto_incr);
        end
        cyc(1'b0, 1'b0, 12'h300, 8'h10, 12'd3, 1'b0);
        pulses += int'(done_auto_incr);
        total++;
        if (busy !== 1'b0 || done_auto_incr !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept busy=%b done=%b want 0/0", busy, done_auto_incr);
        end
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            pulses += int'(done_auto_incr);
            total++;
            if (addr_out !== exp_a[k] || addr_valid !== 1'b1 ||
                done_auto_incr !== (k == 2)) begin
                bad++;
                $display("FAIL b2b_elem%0d addr=%h valid=%b done=%b want %h/1/%b",
                         k, addr_out, addr_valid, done_auto_incr, exp_a[k], k == 2);
            end
        end
        idle(1'b0);
        pulses += int'(done_auto_incr);
        total++;
        if (pulses != 2 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_pulses pulses=%0d busy=%b want 2/0", pulses, busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst         = 1'b1;
        is_not_vect = 1'b1;
        vect_base   = 12'h0;
        vect_stride = 8'h0;
        vect_len    = 12'h0;
        stall       = 1'b0;
        test_reset();
        test_basic();
        test_zero_len();
        test_wrap();
        test_stall();
        test_rst_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
